// File: rtl/perf_mon_pkg.sv
// rtl/perf_mon_pkg.sv - shared types and constants for the sdspi performance monitor
//
// Purpose: measurement FSM state encoding and 2-bit result status codes.
// Ports:   none (package).

package perf_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } perf_state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered rising-edge detector
//
// Purpose: flags a cycle where din is high while its registered copy is low.
//          The copy resets to 0, so a level already high when reset releases
//          is reported as an edge.
// Ports:   clk  - clock, rising edge
//          rst  - synchronous active-high reset
//          din  - level to watch
//          rise - high in the cycle din is high and was low on the previous edge

module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/sdspi_perf_monitor.sv
// rtl/sdspi_perf_monitor.sv - cycle-accurate run monitor for the sdspi UUT handshake
//
// Purpose: times each UUT run from start edge to end edge (or abort/timeout),
//          counts busy cycles, records the outcome and holds the result behind
//          a valid/ready handshake.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          start_uut, end_uut       - UUT start / finish levels (rising edges used)
//          err_uut, busy_uut        - UUT error / busy levels
//          timeout_limit            - max elapsed cycles, 0 disables
//          result_cycles/busy/status- held result
//          result_valid/ready       - result handshake
//          measuring                - a run is in progress
//          run_count                - results captured since reset (wraps)
//          overrun                  - sticky, start edge lost while result held

module sdspi_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int CNT_WIDTH     = 32,
  parameter int RUN_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_uut,
  input  logic                     end_uut,
  input  logic                     err_uut,
  input  logic                     busy_uut,
  input  logic [CNT_WIDTH-1:0]     timeout_limit,
  output logic [CNT_WIDTH-1:0]     result_cycles,
  output logic [CNT_WIDTH-1:0]     result_busy,
  output logic [1:0]               result_status,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     measuring,
  output logic [RUN_CNT_WIDTH-1:0] run_count,
  output logic                     overrun
);

  localparam logic [CNT_WIDTH-1:0]     CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RUN_CNT_WIDTH-1:0] RUN_ONE = {{(RUN_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic start_rise, end_rise;

  edge_detect u_start_edge (.clk(clk), .rst(rst), .din(start_uut), .rise(start_rise));
  edge_detect u_end_edge   (.clk(clk), .rst(rst), .din(end_uut),   .rise(end_rise));

  perf_state_t state, state_next;

  logic [CNT_WIDTH-1:0] elapsed, busy_cnt;
  logic                 err_seen;

  // Counter values as they stand after this cycle's RUN update; these are
  // what a terminating edge captures and what the timeout compares against.
  logic [CNT_WIDTH-1:0] elapsed_upd, busy_upd;
  logic                 err_upd;

  assign elapsed_upd = (elapsed == CNT_MAX) ? elapsed : elapsed + CNT_ONE;
  assign busy_upd    = (busy_uut && busy_cnt != CNT_MAX) ? busy_cnt + CNT_ONE : busy_cnt;
  assign err_upd     = err_seen | err_uut;

  logic       init_run;
  logic       capture;
  logic [1:0] cap_status;
  logic       set_overrun;

  always_comb begin
    state_next  = state;
    init_run    = 1'b0;
    capture     = 1'b0;
    cap_status  = ST_OK;
    set_overrun = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_next = RUN;
          init_run   = 1'b1;
        end
      end
      RUN: begin
        if (end_rise) begin
          capture    = 1'b1;
          cap_status = err_upd ? ST_ERR : ST_OK;
        end else if (start_rise) begin
          capture    = 1'b1;
          cap_status = ST_ABORT;
        end else if (timeout_limit != '0 && elapsed_upd == timeout_limit) begin
          capture    = 1'b1;
          cap_status = ST_TIMEOUT;
        end
        if (capture) state_next = HOLD;
      end
      HOLD: begin
        if (result_ready) begin
          // A start coinciding with the handshake is not lost: go straight to RUN.
          if (start_rise) begin
            state_next = RUN;
            init_run   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (start_rise) begin
          set_overrun = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      elapsed       <= '0;
      busy_cnt      <= '0;
      err_seen      <= 1'b0;
      result_cycles <= '0;
      result_busy   <= '0;
      result_status <= ST_OK;
      run_count     <= '0;
      overrun       <= 1'b0;
    end else begin
      state <= state_next;
      if (init_run) begin
        elapsed  <= '0;
        busy_cnt <= '0;
        err_seen <= 1'b0;
      end else if (state == RUN) begin
        elapsed  <= elapsed_upd;
        busy_cnt <= busy_upd;
        err_seen <= err_upd;
      end
      if (capture) begin
        result_cycles <= elapsed_upd;
        result_busy   <= busy_upd;
        result_status <= cap_status;
        run_count     <= run_count + RUN_ONE;
      end
      if (set_overrun) overrun <= 1'b1;
    end
  end

  assign result_valid = (state == HOLD);
  assign measuring    = (state == RUN);

endmodule

// File: tb/tb_sdspi_perf_monitor.sv
// tb/tb_sdspi_perf_monitor.sv - self-checking bench for sdspi_perf_monitor

module tb_sdspi_perf_monitor;
  import perf_mon_pkg::*;

  localparam int W  = 32;
  localparam int RW = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_uut, end_uut, err_uut, busy_uut, result_ready;
  logic [W-1:0]  timeout_limit;
  logic [W-1:0]  result_cycles, result_busy;
  logic [1:0]    result_status;
  logic          result_valid, measuring, overrun;
  logic [RW-1:0] run_count;

  logic [SW-1:0] s_limit;
  logic [SW-1:0] s_cycles, s_busy;
  logic [1:0]    s_status;
  logic          s_valid, s_measuring, s_overrun;
  logic [RW-1:0] s_run_count;

  always #5 clk = ~clk;

  sdspi_perf_monitor #(.CNT_WIDTH(W), .RUN_CNT_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .start_uut(start_uut), .end_uut(end_uut),
    .err_uut(err_uut), .busy_uut(busy_uut), .timeout_limit(timeout_limit),
    .result_cycles(result_cycles), .result_busy(result_busy),
    .result_status(result_status), .result_valid(result_valid),
    .result_ready(result_ready), .measuring(measuring),
    .run_count(run_count), .overrun(overrun)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles.
  sdspi_perf_monitor #(.CNT_WIDTH(SW), .RUN_CNT_WIDTH(RW)) dut_sat (
    .clk(clk), .rst(rst), .start_uut(start_uut), .end_uut(end_uut),
    .err_uut(err_uut), .busy_uut(busy_uut), .timeout_limit(s_limit),
    .result_cycles(s_cycles), .result_busy(s_busy),
    .result_status(s_status), .result_valid(s_valid),
    .result_ready(result_ready), .measuring(s_measuring),
    .run_count(s_run_count), .overrun(s_overrun)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int exp_runs = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start_uut = 1'b0; end_uut = 1'b0; err_uut = 1'b0; busy_uut = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    exp_runs = 0;
  endtask

  typedef struct {
    int         run_len;    // end edge offset from start, 0 = no end
    int         busy_len;   // busy high on offsets 1..busy_len
    int         err_at;     // err pulse offset, 0 = none
    int         limit;
    int         exp_cycles;
    int         exp_busy;
    logic [1:0] exp_status;
  } vec_t;

  vec_t vecs[6];

  // Higher-level reference: timestamps and running sums, not counters.
  bit          m_run, m_hold, m_ovr, m_err, m_ps, m_pe;
  longint      m_t, m_t0, m_bsum, m_cyc, m_bus;
  logic [1:0]  m_st;
  int          m_cnt;

  task automatic model_reset;
    m_run = 0; m_hold = 0; m_ovr = 0; m_err = 0; m_ps = 0; m_pe = 0;
    m_t = 0; m_t0 = 0; m_bsum = 0; m_cyc = 0; m_bus = 0; m_st = ST_OK; m_cnt = 0;
  endtask

  task automatic model_begin;
    m_run = 1; m_t0 = m_t; m_bsum = 0; m_err = 0;
  endtask

  task automatic model_step(input bit s, input bit e, input bit er, input bit b,
                            input bit rd, input longint lim);
    bit se, ee, fin;
    longint el;
    se = s && !m_ps; ee = e && !m_pe;
    m_ps = s; m_pe = e;
    m_t++;
    if (m_run) begin
      m_bsum += b;
      m_err  = m_err | er;
      el  = m_t - m_t0;
      fin = 1;
      if (ee)                         m_st = m_err ? ST_ERR : ST_OK;
      else if (se)                    m_st = ST_ABORT;
      else if (lim != 0 && el == lim) m_st = ST_TIMEOUT;
      else                            fin = 0;
      if (fin) begin
        m_run = 0; m_hold = 1; m_cyc = el; m_bus = m_bsum; m_cnt++;
      end
    end else if (m_hold) begin
      if (rd) begin
        m_hold = 0;
        if (se) model_begin();
      end else if (se) begin
        m_ovr = 1;
      end
    end else if (se) begin
      model_begin();
    end
  endtask

  initial begin
    bit got;
    int at;
    bit saw_valid;

    vecs[0] = '{40, 30,  0,   0,  40,  30, ST_OK};
    vecs[1] = '{25,  0,  7,   0,  25,   0, ST_ERR};
    vecs[2] = '{12, 12, 12,   0,  12,  12, ST_ERR};
    vecs[3] = '{ 0,100,  0, 100, 100, 100, ST_TIMEOUT};
    vecs[4] = '{30,  5,  0,  30,  30,   5, ST_OK};
    vecs[5] = '{ 1,  1,  0,   0,   1,   1, ST_OK};

    timeout_limit = '0;
    s_limit       = '0;
    result_ready  = 1'b1;

    // Reset state
    do_reset();
    chk("reset valid", result_valid, 0);
    chk("reset measuring", measuring, 0);
    chk("reset run_count", run_count, 0);
    chk("reset overrun", overrun, 0);
    chk("reset cycles", result_cycles, 0);
    chk("reset busy", result_busy, 0);
    chk("reset status", result_status, 0);

    // Start level already high when reset releases counts as an edge
    rst = 1'b1; start_uut = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("level-at-reset measuring", measuring, 1);
    start_uut = 1'b0; end_uut = 1'b1;
    tick();
    end_uut = 1'b0;
    exp_runs++;
    chk("level-at-reset valid", result_valid, 1);
    chk("level-at-reset cycles", result_cycles, 1);
    tick();

    // Table-driven runs, ready held high
    for (int v = 0; v < 6; v++) begin
      timeout_limit = W'(vecs[v].limit);
      result_ready  = 1'b1;
      start_uut = 1'b1;
      tick();
      start_uut = 1'b0;
      got = 0; at = 0;
      for (int i = 1; i <= 200 && !got; i++) begin
        busy_uut = (i <= vecs[v].busy_len);
        err_uut  = (i == vecs[v].err_at);
        end_uut  = (i == vecs[v].run_len);
        tick();
        if (result_valid) begin got = 1; at = i; end
      end
      idle_inputs();
      exp_runs++;
      chk($sformatf("vec%0d valid", v), got, 1);
      chk($sformatf("vec%0d valid edge", v), at, vecs[v].exp_cycles);
      chk($sformatf("vec%0d cycles", v), result_cycles, vecs[v].exp_cycles);
      chk($sformatf("vec%0d busy", v), result_busy, vecs[v].exp_busy);
      chk($sformatf("vec%0d status", v), result_status, vecs[v].exp_status);
      chk($sformatf("vec%0d run_count", v), run_count, exp_runs);
      chk($sformatf("vec%0d measuring", v), measuring, 0);
      tick();
      chk($sformatf("vec%0d valid one cycle", v), result_valid, 0);
    end
    timeout_limit = '0;

    // Abort by second start 20 cycles in; later end edges ignored
    result_ready = 1'b0;
    start_uut = 1'b1; tick(); start_uut = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    start_uut = 1'b1; tick();
    exp_runs++;
    chk("abort valid", result_valid, 1);
    chk("abort status", result_status, ST_ABORT);
    chk("abort cycles", result_cycles, 20);
    start_uut = 1'b0; end_uut = 1'b1; tick(); end_uut = 1'b0; tick();
    chk("abort held cycles", result_cycles, 20);
    chk("abort held status", result_status, ST_ABORT);
    chk("abort held valid", result_valid, 1);
    chk("abort overrun", overrun, 0);
    result_ready = 1'b1; tick();
    chk("abort released", result_valid, 0);
    end_uut = 1'b1; tick(); end_uut = 1'b0; tick();
    chk("idle end ignored measuring", measuring, 0);
    chk("idle end ignored valid", result_valid, 0);
    chk("idle end ignored run_count", run_count, exp_runs);

    // Overrun while held, then handshake with simultaneous start
    result_ready = 1'b0;
    start_uut = 1'b1; tick(); start_uut = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    end_uut = 1'b1; tick(); end_uut = 1'b0;
    exp_runs++;
    chk("ovr first cycles", result_cycles, 5);
    start_uut = 1'b1; tick();
    chk("ovr overrun", overrun, 1);
    chk("ovr result unchanged", result_cycles, 5);
    chk("ovr still valid", result_valid, 1);
    chk("ovr not measuring", measuring, 0);
    start_uut = 1'b0; tick();
    result_ready = 1'b1; start_uut = 1'b1; tick();
    start_uut = 1'b0;
    chk("ready+start measuring", measuring, 1);
    chk("ready+start valid", result_valid, 0);
    tick(); tick();
    end_uut = 1'b1; tick(); end_uut = 1'b0;
    exp_runs++;
    chk("ready+start cycles", result_cycles, 3);
    chk("ready+start run_count", run_count, exp_runs);
    tick();

    // Reset mid-run clears everything including sticky overrun
    start_uut = 1'b1; tick(); start_uut = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick();
    chk("midrun rst measuring", measuring, 0);
    chk("midrun rst valid", result_valid, 0);
    chk("midrun rst run_count", run_count, 0);
    chk("midrun rst overrun", overrun, 0);
    chk("midrun rst cycles", result_cycles, 0);
    rst = 1'b0; exp_runs = 0;
    tick();

    // timeout_limit 0: no result however long the run
    timeout_limit = '0;
    saw_valid = 0;
    start_uut = 1'b1; tick(); start_uut = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      busy_uut = 1'($urandom);
      tick();
      if (result_valid) saw_valid = 1;
    end
    busy_uut = 1'b0;
    chk("no-timeout valid", saw_valid, 0);
    chk("no-timeout measuring", measuring, 1);

    // Saturation on the narrow instance
    do_reset();
    result_ready = 1'b1;
    start_uut = 1'b1; tick(); start_uut = 1'b0;
    busy_uut = 1'b1;
    for (int i = 1; i < 30; i++) tick();
    end_uut = 1'b1; tick();
    idle_inputs();
    chk("sat valid", s_valid, 1);
    chk("sat cycles", s_cycles, 15);
    chk("sat busy", s_busy, 15);
    chk("sat status", s_status, ST_OK);
    chk("wide cycles", result_cycles, 30);
    chk("wide busy", result_busy, 30);
    tick();

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      timeout_limit = (c < 2000) ? W'(37) : '0;
      start_uut    = ($urandom_range(0, 9) == 0);
      end_uut      = ($urandom_range(0, 14) == 0);
      err_uut      = ($urandom_range(0, 29) == 0);
      busy_uut     = 1'($urandom);
      result_ready = ($urandom_range(0, 2) == 0);
      model_step(start_uut, end_uut, err_uut, busy_uut, result_ready, longint'(timeout_limit));
      tick();
      chk("rnd valid", result_valid, m_hold);
      chk("rnd measuring", measuring, m_run);
      chk("rnd run_count", run_count, m_cnt % 65536);
      chk("rnd overrun", overrun, m_ovr);
      if (m_hold) begin
        chk("rnd cycles", result_cycles, m_cyc);
        chk("rnd busy", result_busy, m_bus);
        chk("rnd status", result_status, m_st);
      end
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
